// File: rtl/wb_regfile_sb_pkg.sv
// Shared constants for the writeback register file and its pending-write scoreboard.
package wb_regfile_sb_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned NREG   = 32;
   localparam int unsigned PEND_W = 2;
   localparam int unsigned REG_AW = 5;

   localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_regfile_sb_sb_counter.sv
// One per-register pending-write counter: saturating up/down with a synchronous clear.
module sb_counter
   import wb_regfile_sb_pkg::*;
#(
   parameter int unsigned W = PEND_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         at_max
);

   logic [W-1:0] count_q;

   assign count  = count_q;
   assign at_max = &count_q;

   // Simultaneous inc and dec cancel; the guards keep the counter from wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count_q <= '0;
      end else if (inc && !dec && !at_max) begin
         count_q <= count_q + W'(1);
      end else if (dec && !inc && count_q != '0) begin
         count_q <= count_q - W'(1);
      end
   end

endmodule

// File: rtl/wb_regfile_sb.sv
// Integer register file fed by the MEM/WB writeback port, with write-through read
// bypass, a per-register pending-write scoreboard and a retired-instruction counter.
module wb_regfile_sb #(
   parameter int unsigned XLEN   = wb_regfile_sb_pkg::XLEN,
   parameter int unsigned NREG   = wb_regfile_sb_pkg::NREG,
   parameter int unsigned PEND_W = wb_regfile_sb_pkg::PEND_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_we_i,
   input  logic [4:0]      wb_waddr_i,
   input  logic [XLEN-1:0] wb_wdata_i,
   input  logic            wb_commit_i,
   input  logic            issue_valid_i,
   input  logic            issue_we_i,
   input  logic [4:0]      issue_rd_i,
   input  logic            flush_i,
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   output logic            rs1_busy_o,
   output logic            rs2_busy_o,
   output logic            issue_ready_o,
   output logic [63:0]     instret_o,
   output logic            sb_err_o
);
   import wb_regfile_sb_pkg::*;

   logic [XLEN-1:0]   regs [1:NREG-1];
   logic [PEND_W-1:0] pend [NREG];
   logic [NREG-1:0]   inc;
   logic [NREG-1:0]   dec;
   logic [NREG-1:0]   at_max;
   logic              issue_fire;
   logic              wb_write;
   logic [63:0]       instret_q;
   logic              sb_err_q;

   assign wb_write   = wb_we_i && (wb_waddr_i != REG_ZERO);
   assign issue_fire = issue_valid_i && issue_we_i && issue_ready_o && !flush_i;

   // x0 has no counter; tie its slot off so lookups by address stay uniform.
   assign pend[0]   = '0;
   assign inc[0]    = 1'b0;
   assign dec[0]    = 1'b0;
   assign at_max[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_pend
      assign inc[r] = issue_fire && (issue_rd_i == REG_AW'(r));
      assign dec[r] = wb_we_i && (wb_waddr_i == REG_AW'(r)) && (pend[r] != '0);

      sb_counter #(
         .W (PEND_W)
      ) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .clear  (flush_i),
         .inc    (inc[r]),
         .dec    (dec[r]),
         .count  (pend[r]),
         .at_max (at_max[r])
      );
   end

   // A full counter can still accept an issue when one of its writes drains this cycle.
   assign issue_ready_o = !(issue_we_i && (issue_rd_i != REG_ZERO) &&
                            at_max[issue_rd_i] && !dec[issue_rd_i]);

   function automatic logic [XLEN-1:0] read_data(input logic [4:0] addr);
      logic [XLEN-1:0] d;
      d = '0;
      if (addr == REG_ZERO) begin
         d = '0;
      end else if (wb_we_i && (wb_waddr_i == addr)) begin
         d = wb_wdata_i;
      end else begin
         d = regs[addr];
      end
      return d;
   endfunction

   // Busy clears only when the completing writeback is the sole outstanding one.
   function automatic logic read_busy(input logic [4:0] addr);
      logic bypass;
      bypass = wb_we_i && (wb_waddr_i == addr) && (addr != REG_ZERO);
      return (pend[addr] != '0) && !(bypass && (pend[addr] == PEND_W'(1)));
   endfunction

   always_comb begin
      rs1_data_o = read_data(rs1_addr_i);
      rs2_data_o = read_data(rs2_addr_i);
      rs1_busy_o = read_busy(rs1_addr_i);
      rs2_busy_o = read_busy(rs2_addr_i);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_write) begin
         regs[wb_waddr_i] <= wb_wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instret_q <= '0;
         sb_err_q  <= 1'b0;
      end else begin
         if (wb_commit_i) begin
            instret_q <= instret_q + 64'd1;
         end
         if (wb_write && (pend[wb_waddr_i] == '0)) begin
            sb_err_q <= 1'b1;
         end
      end
   end

   assign instret_o = instret_q;
   assign sb_err_o  = sb_err_q;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed bench for wb_regfile_sb: reset, bypass, x0, saturation, flush, retire count.
module tb_wb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic        wb_we_i;
   logic [4:0]  wb_waddr_i;
   logic [63:0] wb_wdata_i;
   logic        wb_commit_i;
   logic        issue_valid_i;
   logic        issue_we_i;
   logic [4:0]  issue_rd_i;
   logic        flush_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic [63:0] rs1_data_o;
   logic [63:0] rs2_data_o;
   logic        rs1_busy_o;
   logic        rs2_busy_o;
   logic        issue_ready_o;
   logic [63:0] instret_o;
   logic        sb_err_o;

   int vectors;
   int miscompares;

   wb_regfile_sb #(
      .XLEN   (64),
      .NREG   (32),
      .PEND_W (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_we_i       (wb_we_i),
      .wb_waddr_i    (wb_waddr_i),
      .wb_wdata_i    (wb_wdata_i),
      .wb_commit_i   (wb_commit_i),
      .issue_valid_i (issue_valid_i),
      .issue_we_i    (issue_we_i),
      .issue_rd_i    (issue_rd_i),
      .flush_i       (flush_i),
      .rs1_addr_i    (rs1_addr_i),
      .rs2_addr_i    (rs2_addr_i),
      .rs1_data_o    (rs1_data_o),
      .rs2_data_o    (rs2_data_o),
      .rs1_busy_o    (rs1_busy_o),
      .rs2_busy_o    (rs2_busy_o),
      .issue_ready_o (issue_ready_o),
      .instret_o     (instret_o),
      .sb_err_o      (sb_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_we_i       = 1'b0;
      wb_waddr_i    = '0;
      wb_wdata_i    = '0;
      wb_commit_i   = 1'b0;
      issue_valid_i = 1'b0;
      issue_we_i    = 1'b0;
      issue_rd_i    = '0;
      flush_i       = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid_i = 1'b1;
      issue_we_i    = 1'b1;
      issue_rd_i    = rd;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [63:0] d);
      wb_we_i    = 1'b1;
      wb_waddr_i = rd;
      wb_wdata_i = d;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      idle();
      rs1_addr_i = 5'd5;
      rs2_addr_i = 5'd0;
      rst_n      = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_rs1_data", rs1_data_o, 64'd0);
      chk("rst_rs2_data", rs2_data_o, 64'd0);
      chk("rst_rs1_busy", rs1_busy_o, 1'b0);
      chk("rst_rs2_busy", rs2_busy_o, 1'b0);
      chk("rst_instret", instret_o, 64'd0);
      chk("rst_sb_err", sb_err_o, 1'b0);
      chk("rst_ready", issue_ready_o, 1'b1);

      // issue x5, then same-cycle bypass of the writeback
      issue(5'd5);
      tick();
      idle();
      #1;
      chk("x5_busy", rs1_busy_o, 1'b1);
      wb(5'd5, 64'hDEAD_BEEF);
      rs2_addr_i = 5'd5;
      #1;
      chk("x5_bypass_data", rs1_data_o, 64'hDEAD_BEEF);
      chk("x5_bypass_busy", rs1_busy_o, 1'b0);
      chk("x5_bypass_rs2", rs2_data_o, 64'hDEAD_BEEF);
      tick();
      idle();
      #1;
      chk("x5_reg_data", rs1_data_o, 64'hDEAD_BEEF);
      chk("x5_reg_busy", rs1_busy_o, 1'b0);
      chk("x5_no_err", sb_err_o, 1'b0);

      // x0 writes are dropped and never tracked
      issue(5'd0);
      tick();
      idle();
      rs1_addr_i = 5'd0;
      wb(5'd0, 64'h1234);
      #1;
      chk("x0_bypass_data", rs1_data_o, 64'd0);
      chk("x0_busy", rs1_busy_o, 1'b0);
      tick();
      idle();
      #1;
      chk("x0_data", rs1_data_o, 64'd0);
      chk("x0_no_err", sb_err_o, 1'b0);

      // x7 saturates at three in-flight writes
      rs1_addr_i = 5'd7;
      issue(5'd7);
      tick();
      tick();
      tick();
      #1;
      chk("x7_full_ready", issue_ready_o, 1'b0);
      chk("x7_full_busy", rs1_busy_o, 1'b1);
      wb(5'd7, 64'h77);
      #1;
      chk("x7_drain_ready", issue_ready_o, 1'b1);
      chk("x7_drain_busy", rs1_busy_o, 1'b1);
      chk("x7_drain_data", rs1_data_o, 64'h77);
      tick();
      wb_we_i = 1'b0;
      #1;
      chk("x7_still_full", issue_ready_o, 1'b0);
      idle();
      wb(5'd7, 64'h1);
      #1;
      chk("x7_pend3_busy", rs1_busy_o, 1'b1);
      tick();
      wb(5'd7, 64'h2);
      #1;
      chk("x7_pend2_busy", rs1_busy_o, 1'b1);
      tick();
      wb(5'd7, 64'h3);
      #1;
      chk("x7_pend1_busy", rs1_busy_o, 1'b0);
      tick();
      idle();
      #1;
      chk("x7_final_data", rs1_data_o, 64'h3);
      chk("x7_final_busy", rs1_busy_o, 1'b0);
      chk("x7_no_err", sb_err_o, 1'b0);

      // flush clears pending counts but the writeback still lands
      rs1_addr_i = 5'd3;
      rs2_addr_i = 5'd9;
      issue(5'd3);
      tick();
      tick();
      idle();
      #1;
      chk("x3_busy", rs1_busy_o, 1'b1);
      flush_i = 1'b1;
      wb(5'd3, 64'h55);
      issue(5'd9);
      tick();
      idle();
      #1;
      chk("flush_x3_data", rs1_data_o, 64'h55);
      chk("flush_x3_busy", rs1_busy_o, 1'b0);
      chk("flush_x9_noissue", rs2_busy_o, 1'b0);
      chk("flush_no_err", sb_err_o, 1'b0);
      wb(5'd3, 64'h66);
      tick();
      idle();
      #1;
      chk("stray_wb_err", sb_err_o, 1'b1);
      chk("stray_wb_data", rs1_data_o, 64'h66);

      // retire counter ignores flush
      for (int i = 0; i < 10; i++) begin
         wb_commit_i = 1'b1;
         flush_i     = (i % 2 == 1) && (i < 8);
         tick();
      end
      idle();
      #1;
      chk("instret_10", instret_o, 64'd10);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      release dut.instret_q;
      wb_commit_i = 1'b1;
      tick();
      chk("instret_max", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      chk("instret_wrap", instret_o, 64'd0);
      tick();
      idle();
      #1;
      chk("instret_one", instret_o, 64'd1);

      // reset dominates simultaneous activity
      issue(5'd3);
      wb(5'd3, 64'hAA);
      wb_commit_i = 1'b1;
      rst_n       = 1'b0;
      tick();
      rst_n = 1'b1;
      idle();
      #1;
      chk("rst2_instret", instret_o, 64'd0);
      chk("rst2_sb_err", sb_err_o, 1'b0);
      chk("rst2_x3_data", rs1_data_o, 64'd0);
      chk("rst2_x3_busy", rs1_busy_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_regfile_sb.md
Name: wb_regfile_sb

Overview:
- Receiving end of the MEM/WB stage interface: a 32 x XLEN integer register file written by the writeback port.
- Provides two combinational read ports to the decode stage, with write-through bypass from the same-cycle writeback.
- Holds a per-register pending-write scoreboard: decode marks rd on issue, writeback clears it.
- Counts retired instructions from the commit strobe, giving the decode stage hazard status and the difftest harness a retire count.

Parameters:
XLEN, 64, register and data width
NREG, 32, number of architectural registers (x0 hardwired to zero)
PEND_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^PEND_W-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
wb_we_i  in  1  writeback write enable (from MEM/WB register)
wb_waddr_i  in  5  writeback destination register
wb_wdata_i  in  XLEN  writeback data
wb_commit_i  in  1  one instruction retires this cycle
issue_valid_i  in  1  decode issues an instruction this cycle
issue_we_i  in  1  issued instruction writes rd
issue_rd_i  in  5  issued instruction destination
flush_i  in  1  pipeline flush; discards all in-flight writes
rs1_addr_i  in  5  read port 1 address
rs2_addr_i  in  5  read port 2 address
rs1_data_o  out  XLEN  read port 1 data
rs2_data_o  out  XLEN  read port 2 data
rs1_busy_o  out  1  rs1 has an outstanding write not yet visible
rs2_busy_o  out  1  rs2 has an outstanding write not yet visible
issue_ready_o  out  1  issue with issue_we_i on issue_rd_i would be accepted
instret_o  out  64  retired-instruction counter
sb_err_o  out  1  sticky: writeback to a register with zero pending count

Behaviour:
Reset (rst_n=0 at posedge clk):
- All registers 0, all pending counters 0, instret_o 0, sb_err_o 0.
- Read outputs are combinational, so they show 0 after reset.

Write:
- At posedge, if wb_we_i && wb_waddr_i!=0, reg[wb_waddr_i] <= wb_wdata_i.
- Writes to x0 are dropped; x0 always reads 0 and is never busy.

Read, combinational, zero latency:
- rsN_data_o = 0 if rsN_addr_i==0.
- Else wb_wdata_i if wb_we_i && wb_waddr_i==rsN_addr_i (bypass).
- Else reg[rsN_addr_i].

Busy:
- rsN_busy_o = (pend[rsN_addr_i] != 0) minus the bypass case.
- If the only outstanding write (pend==1) is the one completing this cycle via wb_we_i, busy=0.
- pend>1 with a matching writeback: busy=1, because the older write does not satisfy the read.

Scoreboard update per register r!=0 at posedge:
- inc = issue_valid_i && issue_we_i && issue_rd_i==r && issue_ready_o && !flush_i.
- dec = wb_we_i && wb_waddr_i==r && pend[r]!=0.
- inc && dec: unchanged. inc only: +1. dec only: -1.
- flush_i: all counters <= 0 regardless of inc/dec. The register write in the same cycle still happens.

Issue acceptance:
- issue_ready_o = 0 only when issue_we_i && issue_rd_i!=0 && pend[issue_rd_i] == 2^PEND_W-1 && !(matching dec this cycle).
- Otherwise 1. The counter never wraps.

Scoreboard error:
- wb_we_i with wb_waddr_i!=0 and pend[wb_waddr_i]==0 sets sb_err_o (sticky until reset).
- The data is still written.

Retire counter:
- instret_o += 1 on each posedge with wb_commit_i.
- Wraps modulo 2^64.
- Independent of wb_we_i (stores/branches retire without a write).
- Not affected by flush_i.

Reset mid-operation:
- Reset dominates every simultaneous write, issue, flush and commit.
- The cycle after reset, state equals the power-on state.

Decomposition:
- Shared package: XLEN, NREG, PEND_W, register-index width (5), REG_ZERO constant.
- One natural sub-module: sb_counter (one saturating up/down pending counter with inc, dec, clear, max flag), instantiated NREG-1 times.
- Storage, bypass mux and instret stay in the top.

Test Plan:
- Reset then read x5 and x0 -> rs1_data_o=0, rs2_data_o=0, both busy 0, instret_o=0, sb_err_o=0.
- Issue rd=x5 with we, next cycle read x5 -> rs1_busy_o=1. Then wb_we_i, waddr=5, wdata=0xDEAD_BEEF in the same cycle as the read -> rs1_data_o=0xDEADBEEF, busy=0. Next cycle reg holds it, pend=0.
- Write x0 with 0x1234 (after an issue to x0) -> reads 0, never busy, sb_err_o stays 0.
- Issue x7 three times (PEND_W=2) -> issue_ready_o=0 on the 4th attempt. Same 4th cycle with wb to x7 -> issue_ready_o=1 and pend stays 3.
- Issue x3 twice, then flush_i together with wb to x3 (data 0x55) -> all pend 0, x3=0x55. A later wb to x3 with no issue -> sb_err_o=1.
- Assert wb_commit_i for 10 cycles, 4 of them with flush_i -> instret_o=10. Preload instret_o near 2^64-1 via a force in the bench -> it wraps to 0.
